// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch front end. It holds a fetch PC, reads one word per cycle
//   from a combinational instruction memory, and queues {instr, pc} pairs in a
//   small FIFO that feeds the decode stage. A redirect flushes the queue and
//   restarts fetching at the target address.
//
//   Optional feature (macro FETCH_MISALIGN_TRAP_EN):
//     defined   - a redirect to a target that is not word aligned loads that
//                 target, raises fetch_misalign and halts fetching until the
//                 next aligned redirect or reset.
//     undefined - redirect targets have bits [1:0] forced to zero and
//                 fetch_misalign is constant 0.
//
// Parameters
//   RESET_PC   fetch PC after reset
//   BUF_DEPTH  instruction buffer entries (2 or 4)
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active low
//   imem_addr       byte address to instruction memory (current fetch PC)
//   imem_instr      instruction word for imem_addr, same cycle
//   redirect_valid  flush and restart at redirect_pc
//   redirect_pc     redirect target byte address
//   id_ready        decode accepts the head entry this cycle
//   if_valid        head entry valid
//   if_instr        head entry instruction
//   if_pc           head entry PC
//   if_pc_plus4     if_pc + 4 (wraps modulo 2^32)
//   fetch_misalign  misaligned redirect flag
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_misalign
);

  localparam int               PTR_W    = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BUF_DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  logic [31:0]      fetch_pc_p0;
  logic             halted;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      buf_instr_p1 [BUF_DEPTH];
  logic [31:0]      buf_pc_p1    [BUF_DEPTH];

  logic             full;
  logic             pop;
  logic             push;
  logic [31:0]      redir_target;
  logic             redir_misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_target     = redirect_pc;
  assign redir_misaligned = |redirect_pc[1:0];
`else
  assign redir_target     = redirect_pc & 32'hFFFF_FFFC;
  assign redir_misaligned = 1'b0;
`endif

  assign full = (count == FULL_CNT);
  assign pop  = if_valid & id_ready;
  // A pop frees a slot on the same edge, so a full buffer can still accept.
  assign push = (~full | pop) & ~redirect_valid & ~halted;

  assign imem_addr = fetch_pc_p0;

  // Stage p0: fetch PC, buffer pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_p0 <= RESET_PC;
      halted      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      // Redirect overrides pop, push and full: everything buffered is stale.
      fetch_pc_p0 <= redir_target;
      halted      <= redir_misaligned;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (push) begin
        fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage p1: buffer payload (no reset; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_p1[wr_ptr] <= imem_instr;
      buf_pc_p1[wr_ptr]    <= fetch_pc_p0;
    end
  end

  // Payload is masked while the head is empty so reset presents zeros.
  assign if_valid       = (count != '0);
  assign if_instr       = if_valid ? buf_instr_p1[rd_ptr] : 32'h0;
  assign if_pc          = if_valid ? buf_pc_p1[rd_ptr] : 32'h0;
  assign if_pc_plus4    = if_pc + 32'd4;
  assign fetch_misalign = halted;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_misalign;

  logic        id_ready2;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_instr2;
  logic        if_valid2;
  logic [31:0] if_instr2;
  logic [31:0] if_pc2;
  logic [31:0] if_pc_plus4_2;
  logic        fetch_misalign2;

  // Memory word i holds 32'h1000_0000 + i
  assign imem_instr  = 32'h1000_0000 + {2'b00, imem_addr[31:2]};
  assign imem_instr2 = 32'h1000_0000 + {2'b00, imem_addr2[31:2]};

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .fetch_misalign(fetch_misalign)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .id_ready(id_ready2),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
    .if_pc_plus4(if_pc_plus4_2), .fetch_misalign(fetch_misalign2)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    id_ready        = 1'b0;
    id_ready2       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    redirect_valid2 = 1'b0;
    redirect_pc2    = 32'h0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_valid",    {31'h0, if_valid}, 32'h0);
    check("rst_instr",    if_instr, 32'h0);
    check("rst_pc",       if_pc, 32'h0);
    check("rst_pc4",      if_pc_plus4, 32'h4);
    check("rst_addr",     imem_addr, 32'h0);
    check("rst_misalign", {31'h0, fetch_misalign}, 32'h0);
    check("rst_addr2",    imem_addr2, 32'hFFFF_FFF8);
    check("rst_valid2",   {31'h0, if_valid2}, 32'h0);
    tick;
    tick;
    check("rst_hold_valid", {31'h0, if_valid}, 32'h0);
    check("rst_hold_addr",  imem_addr, 32'h0);

    // Release with decode stalled: buffers fill and hold
    rst = 1'b1;
    tick;
    check("first_valid", {31'h0, if_valid}, 32'h1);
    check("first_pc",    if_pc, 32'h0);
    check("first_instr", if_instr, 32'h1000_0000);
    check("first_addr",  imem_addr, 32'h4);
    tick; tick; tick; tick;
    check("full_addr",   imem_addr, 32'h8);
    check("full_pc",     if_pc, 32'h0);
    check("full_valid",  {31'h0, if_valid}, 32'h1);
    check("full_addr2",  imem_addr2, 32'h0000_0008);
    check("full_pc2",    if_pc2, 32'hFFFF_FFF8);

    // Drain: one instruction per cycle, none lost or duplicated
    id_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      check("stream_pc",    if_pc, 32'(4 * k));
      check("stream_instr", if_instr, 32'h1000_0000 + 32'(k));
      check("stream_pc4",   if_pc_plus4, 32'(4 * k + 4));
    end
    check("stream_addr", imem_addr, 32'd24);

    // Redirect while full with id_ready high
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    check("redir_cycle_valid", {31'h0, if_valid}, 32'h1);
    check("redir_cycle_pc",    if_pc, 32'd16);
    tick;
    redirect_valid = 1'b0;
    check("redir_valid", {31'h0, if_valid}, 32'h0);
    check("redir_addr",  imem_addr, 32'h100);
    tick;
    check("redir_pc",    if_pc, 32'h100);
    check("redir_instr", if_instr, 32'h1000_0040);
    check("redir_v1",    {31'h0, if_valid}, 32'h1);
    tick;
    check("redir_pc_next", if_pc, 32'h104);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick;
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_flag",  {31'h0, fetch_misalign}, 32'h1);
    check("mis_valid", {31'h0, if_valid}, 32'h0);
    check("mis_addr",  imem_addr, 32'h102);
    tick;
    tick;
    check("mis_halt_valid", {31'h0, if_valid}, 32'h0);
    check("mis_halt_flag",  {31'h0, fetch_misalign}, 32'h1);
    check("mis_halt_addr",  imem_addr, 32'h102);
`else
    check("mis_flag",  {31'h0, fetch_misalign}, 32'h0);
    check("mis_addr",  imem_addr, 32'h100);
    check("mis_valid", {31'h0, if_valid}, 32'h0);
    tick;
    check("mis_pc",    if_pc, 32'h100);
    check("mis_v1",    {31'h0, if_valid}, 32'h1);
    tick;
    check("mis_pc_next", if_pc, 32'h104);
`endif

    // Aligned redirect clears any trap
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick;
    redirect_valid = 1'b0;
    check("al_flag",  {31'h0, fetch_misalign}, 32'h0);
    check("al_addr",  imem_addr, 32'h200);
    check("al_valid", {31'h0, if_valid}, 32'h0);
    tick;
    check("al_v1", {31'h0, if_valid}, 32'h1);
    check("al_pc", if_pc, 32'h200);

    // Two entries buffered, then reset mid-stream
    id_ready = 1'b0;
    tick;
    check("two_addr", imem_addr, 32'h208);
    check("two_pc",   if_pc, 32'h200);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    check("mid_rst_addr",  imem_addr, 32'h0);
    check("mid_rst_pc",    if_pc, 32'h0);
    check("mid_rst_pc4",   if_pc_plus4, 32'h4);
    tick;
    check("mid_rst_hold", {31'h0, if_valid}, 32'h0);

    // Release with decode ready: streams from RESET_PC on both instances
    id_ready  = 1'b1;
    id_ready2 = 1'b1;
    rst       = 1'b1;
    tick;
    check("rel_pc0",    if_pc, 32'h0);
    check("rel_instr0", if_instr, 32'h1000_0000);
    check("wrap_pc0",   if_pc2, 32'hFFFF_FFF8);
    check("wrap_instr0", if_instr2, 32'h4FFF_FFFE);
    tick;
    check("rel_pc1",    if_pc, 32'h4);
    check("rel_instr1", if_instr, 32'h1000_0001);
    check("wrap_pc1",   if_pc2, 32'hFFFF_FFFC);
    check("wrap_pc4_1", if_pc_plus4_2, 32'h0);
    tick;
    check("rel_pc2",    if_pc, 32'h8);
    check("rel_instr2", if_instr, 32'h1000_0002);
    check("wrap_pc2",   if_pc2, 32'h0);
    check("wrap_pc4_2", if_pc_plus4_2, 32'h4);
    check("wrap_instr2", if_instr2, 32'h1000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
